// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL lock supervisor and staggered reset release.
// Qualifies an asynchronous PLL lock, holds every downstream reset for
// HOLD_CYCLES, then releases N_OUT domains one at a time, STAGE_CYCLES
// apart. Lock loss or a software request re-asserts all domains at once.
//
// Ports:
//   clk_i           system clock (single clock domain)
//   reset_i         asynchronous active-high reset
//   pll_locked_i    PLL lock, asynchronous to clk_i
//   sw_reset_i      synchronous software reset request, level-sampled
//   reset_o         per-domain active-high resets, bit 0 released first
//   ready_o         high once every domain is released
//   state_o         0 WAIT_LOCK, 1 HOLD, 2 STAGE, 3 RUN
//   lock_loss_cnt_o saturating count of lock-loss events
module reset_sequencer #(
    parameter int N_OUT        = 2,
    parameter int HOLD_CYCLES  = 255,
    parameter int STAGE_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pll_locked_i,
    input  logic             sw_reset_i,
    output logic [N_OUT-1:0] reset_o,
    output logic             ready_o,
    output logic [1:0]       state_o,
    output logic [7:0]       lock_loss_cnt_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        STAGE     = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int K_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [K_W-1:0]   K_LAST     = K_W'(N_OUT - 1);

    state_t             state;
    logic [1:0]         sync;
    logic               lock_s;
    logic [CNT_W-1:0]   cnt;
    logic [K_W-1:0]     k;
    logic [K_W-1:0]     k_nxt;
    logic [N_OUT-1:0]   rel_mask;

    assign lock_s  = sync[1];
    assign k_nxt   = k + K_W'(1);
    assign state_o = state;

    // One-hot mask of the domain released at the end of the current stage.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < N_OUT; i++) begin
            rel_mask[i] = (k_nxt == K_W'(i));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync            <= 2'b00;
            state           <= WAIT_LOCK;
            cnt             <= '0;
            k               <= '0;
            reset_o         <= '1;
            ready_o         <= 1'b0;
            lock_loss_cnt_o <= 8'd0;
        end else begin
            sync <= {sync[0], pll_locked_i};

            if (state != WAIT_LOCK && !lock_s) begin
                // Lock loss wins over a simultaneous software request.
                state   <= WAIT_LOCK;
                cnt     <= '0;
                k       <= '0;
                reset_o <= '1;
                ready_o <= 1'b0;
                if (lock_loss_cnt_o != 8'hFF) begin
                    lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
                end
            end else if (state != WAIT_LOCK && sw_reset_i) begin
                // Restart the hold window; this edge is the new t0.
                state   <= HOLD;
                cnt     <= '0;
                k       <= '0;
                reset_o <= '1;
                ready_o <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        cnt     <= '0;
                        k       <= '0;
                        reset_o <= '1;
                        ready_o <= 1'b0;
                        if (lock_s) begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt        <= '0;
                            reset_o[0] <= 1'b0;
                            if (N_OUT == 1) begin
                                state   <= RUN;
                                ready_o <= 1'b1;
                            end else begin
                                state <= STAGE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STAGE: begin
                        if (cnt == STAGE_LAST) begin
                            cnt     <= '0;
                            k       <= k_nxt;
                            reset_o <= reset_o & ~rel_mask;
                            if (k_nxt == K_LAST) begin
                                state   <= RUN;
                                ready_o <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        cnt <= '0;
                    end
                    default: begin
                        state <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

endmodule
